// File: rtl/uart_word_fifo_ctrl_pkg.sv
// Shared types and helpers for the UART word-to-FIFO controller.
package uart_fifo_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PARTIAL = 1'b1
    } byte_state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/uart_word_fifo_ctrl_idle_timer.sv
// Inter-byte idle timer: counts while enabled, restarts on kick, and emits a
// registered one-cycle pulse on the edge where the count reaches TIMEOUT_CYCLES-1.
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_kick,
    output logic o_expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count     <= '0;
            o_expired <= 1'b0;
        end else if (!i_enable || i_kick) begin
            count     <= '0;
            o_expired <= 1'b0;
        end else if (count == LAST) begin
            count     <= '0;
            o_expired <= 1'b1;
        end else begin
            count     <= count + 1'b1;
            o_expired <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_word_fifo_ctrl.sv
// Sequences the UART byte-to-word serialiser into the 32-bit receive FIFO:
// byte alignment, timeout resync, 1-deep hold register, overflow and frame accounting.
module uart_word_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int WORDS_PER_FRAME = 1024,
    parameter int CNT_W           = 16
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_byte_recv_sig,
    input  logic              i_word_recv_sig,
    input  logic [WORD_W-1:0] i_word_data,
    input  logic              i_fifo_full,
    input  logic              i_overflow_clear,
    output logic              o_serialiser_reset,
    output logic              o_fifo_wr_en,
    output logic [WORD_W-1:0] o_fifo_wr_data,
    output logic              o_overflow,
    output logic              o_frame_done,
    output logic [CNT_W-1:0]  o_words_in_frame,
    output logic [CNT_W-1:0]  o_drop_count,
    output logic [CNT_W-1:0]  o_resync_count,
    output byte_state_t       o_dbg_state,
    output logic [IDX_W-1:0]  o_dbg_byte_idx
);

    localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    byte_state_t       state;
    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-1:0] hold_data;
    logic              held;
    logic              timer_expired;

    logic last_byte;
    logic misaligned;
    logic timeout;
    logic resync;
    logic drop;
    logic frame_hit;

    // FIFO write handshake: o_fifo_wr_en is the valid, ~i_fifo_full the ready;
    // a word transfers on every edge where both are high, and data is stable while held.
    assign o_fifo_wr_en   = held & ~i_fifo_full;
    assign o_fifo_wr_data = hold_data;
    assign o_dbg_state    = state;
    assign o_dbg_byte_idx = byte_idx;

    // The 4th byte arriving with its word pulse still counts as aligned.
    assign last_byte  = i_byte_recv_sig && (byte_idx == LAST_IDX);
    assign misaligned = i_word_recv_sig && (byte_idx != '0) && !last_byte;
    assign timeout    = (state == S_PARTIAL) && timer_expired && !i_byte_recv_sig;
    assign resync     = misaligned || timeout;
    assign drop       = i_word_recv_sig && held && !o_fifo_wr_en;
    assign frame_hit  = o_fifo_wr_en &&
                        (32'(o_words_in_frame) + 32'd1 == 32'(WORDS_PER_FRAME));

    uart_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_enable (state == S_PARTIAL),
        .i_kick   (i_byte_recv_sig),
        .o_expired(timer_expired)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state              <= S_IDLE;
            byte_idx           <= '0;
            o_serialiser_reset <= 1'b0;
            o_resync_count     <= '0;
        end else begin
            o_serialiser_reset <= resync;
            if (resync) begin
                state          <= S_IDLE;
                byte_idx       <= '0;
                o_resync_count <= CNT_W'(sat_inc(32'(o_resync_count), CNT_MAX));
            end else if (i_byte_recv_sig) begin
                byte_idx <= byte_idx + 1'b1;
                state    <= last_byte ? S_IDLE : S_PARTIAL;
            end
        end
    end

    // A word arriving on a write edge replaces the outgoing one; only a full, blocked slot drops.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_data    <= '0;
            held         <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else begin
            if (i_word_recv_sig && !drop) begin
                hold_data <= i_word_data;
                held      <= 1'b1;
            end else if (o_fifo_wr_en) begin
                held <= 1'b0;
            end
            if (drop) begin
                o_overflow   <= 1'b1;
                o_drop_count <= CNT_W'(sat_inc(32'(o_drop_count), CNT_MAX));
            end else if (i_overflow_clear) begin
                o_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_frame_done     <= 1'b0;
            o_words_in_frame <= '0;
        end else begin
            o_frame_done <= frame_hit;
            if (frame_hit) begin
                o_words_in_frame <= '0;
            end else if (o_fifo_wr_en) begin
                o_words_in_frame <= CNT_W'(sat_inc(32'(o_words_in_frame), CNT_MAX));
            end
        end
    end

endmodule

// File: tb/tb_uart_word_fifo_ctrl.sv
// Directed bench for uart_word_fifo_ctrl: a vector table for the hold/overflow/frame
// paths plus hand-written sequences for alignment, timeout and reset corners.
module tb_uart_word_fifo_ctrl;
    import uart_fifo_pkg::*;

    localparam int CNT_W = 16;

    logic              clk;
    logic              rst_n;
    logic              byte_p;
    logic              word_p;
    logic [31:0]       word_data;
    logic              fifo_full;
    logic              ovf_clr;
    logic              ser_reset;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic              overflow;
    logic              frame_done;
    logic [CNT_W-1:0]  words_in_frame;
    logic [CNT_W-1:0]  drop_count;
    logic [CNT_W-1:0]  resync_count;
    byte_state_t       dbg_state;
    logic [IDX_W-1:0]  dbg_idx;

    int n_checks = 0;
    int n_errors = 0;

    uart_word_fifo_ctrl #(
        .TIMEOUT_CYCLES (20),
        .WORDS_PER_FRAME(3),
        .CNT_W          (CNT_W)
    ) dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_byte_recv_sig   (byte_p),
        .i_word_recv_sig   (word_p),
        .i_word_data       (word_data),
        .i_fifo_full       (fifo_full),
        .i_overflow_clear  (ovf_clr),
        .o_serialiser_reset(ser_reset),
        .o_fifo_wr_en      (wr_en),
        .o_fifo_wr_data    (wr_data),
        .o_overflow        (overflow),
        .o_frame_done      (frame_done),
        .o_words_in_frame  (words_in_frame),
        .o_drop_count      (drop_count),
        .o_resync_count    (resync_count),
        .o_dbg_state       (dbg_state),
        .o_dbg_byte_idx    (dbg_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        byte_p;
        logic        word_p;
        logic [31:0] data;
        logic        full;
        logic        clr;
        logic        exp_wr_en;
        logic [31:0] exp_wr_data;
        logic        exp_ovf;
        logic        exp_done;
        logic [15:0] exp_words;
        logic [15:0] exp_drops;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic b, input logic w, input logic [31:0] d,
                       input logic f, input logic c, input logic ewe, input logic [31:0] ewd,
                       input logic eo, input logic edn, input logic [15:0] ew,
                       input logic [15:0] edr);
        vec_t v;
        v.rst = r; v.byte_p = b; v.word_p = w; v.data = d; v.full = f; v.clr = c;
        v.exp_wr_en = ewe; v.exp_wr_data = ewd; v.exp_ovf = eo; v.exp_done = edn;
        v.exp_words = ew; v.exp_drops = edr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic w, input logic [31:0] d,
                         input logic f, input logic c);
        @(negedge clk);
        byte_p = b; word_p = w; word_data = d; fifo_full = f; ovf_clr = c;
        #1;
    endtask

    task automatic idle(input logic f);
        drive(1'b0, 1'b0, 32'h0, f, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        byte_p = 1'b0; word_p = 1'b0; word_data = '0; fifo_full = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] A = 32'hAAAA0001, B = 32'hBBBB0002;
    localparam logic [31:0] C = 32'hCCCC0003, D = 32'hDDDD0004;
    localparam logic [31:0] W0 = 32'h10000000, W1 = 32'h20000001, W2 = 32'h30000002;

    initial begin
        int first_k;
        int pulses;
        int mask;
        logic [31:0] dat;

        rst_n = 1'b1;
        byte_p = 1'b0; word_p = 1'b0; word_data = '0; fifo_full = 1'b0; ovf_clr = 1'b0;

        // Full FIFO: A held, B dropped, drop-beats-clear, then release.
        //   r     b     w     data  full  clr   wr_en wr_data ovf  done  words drops
        add(1'b1, 1'b0, 1'b1, A,    1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, A,   1'b0, 1'b0, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, A,   1'b0, 1'b0, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, A,   1'b0, 1'b0, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b1, B,    1'b1, 1'b0, 1'b0, A,    1'b0, 1'b0, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, A,   1'b1, 1'b0, 16'd0, 16'd1);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, A,   1'b1, 1'b0, 16'd0, 16'd1);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, A,   1'b1, 1'b0, 16'd1, 16'd1);
        add(1'b0, 1'b0, 1'b1, C,    1'b1, 1'b0, 1'b0, A,    1'b1, 1'b0, 16'd1, 16'd1);
        add(1'b0, 1'b0, 1'b1, D,    1'b1, 1'b1, 1'b0, C,    1'b1, 1'b0, 16'd1, 16'd1);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, C,   1'b1, 1'b0, 16'd1, 16'd2);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, C,   1'b0, 1'b0, 16'd1, 16'd2);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, C,   1'b0, 1'b0, 16'd2, 16'd2);
        // Back-to-back words with FIFO ready: replace-on-write, frame of 3 completes.
        add(1'b1, 1'b0, 1'b1, W0,   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b1, W1,   1'b0, 1'b0, 1'b1, W0,   1'b0, 1'b0, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b1, W2,   1'b0, 1'b0, 1'b1, W1,   1'b0, 1'b0, 16'd1, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, W2,  1'b0, 1'b0, 16'd2, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, W2,  1'b0, 1'b1, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, W2,  1'b0, 1'b0, 16'd0, 16'd0);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) reset_dut();
            drive(vq[i].byte_p, vq[i].word_p, vq[i].data, vq[i].full, vq[i].clr);
            chk($sformatf("vec%0d wr_en", i), wr_en, vq[i].exp_wr_en);
            chk($sformatf("vec%0d wr_data", i), wr_data, vq[i].exp_wr_data);
            chk($sformatf("vec%0d overflow", i), overflow, vq[i].exp_ovf);
            chk($sformatf("vec%0d frame_done", i), frame_done, vq[i].exp_done);
            chk($sformatf("vec%0d words_in_frame", i), words_in_frame, vq[i].exp_words);
            chk($sformatf("vec%0d drop_count", i), drop_count, vq[i].exp_drops);
        end

        // Two aligned words: 4th and 8th byte carry the word pulse.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            dat = (i == 3) ? 32'hDEADBEEF : 32'h01234567;
            drive(1'b1, (i % 4) == 3, dat, 1'b0, 1'b0);
            chk($sformatf("aligned byte%0d wr_en", i), wr_en, 1'b0);
            idle(1'b0);
            chk($sformatf("aligned byte%0d idx", i), dbg_idx, 64'((i + 1) % 4));
            chk($sformatf("aligned byte%0d ser_reset", i), ser_reset, 1'b0);
            if ((i % 4) == 3) begin
                chk($sformatf("aligned word%0d wr_en", i / 4), wr_en, 1'b1);
                chk($sformatf("aligned word%0d data", i / 4), wr_data, dat);
            end
        end
        chk("aligned overflow", overflow, 1'b0);
        chk("aligned resync_count", resync_count, 16'd0);

        // Word pulse mid-word forces a resync but is still written.
        reset_dut();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
        idle(1'b0);
        chk("misalign ser_reset", ser_reset, 1'b1);
        chk("misalign wr_en", wr_en, 1'b1);
        chk("misalign wr_data", wr_data, 32'h5A5A5A5A);
        chk("misalign idx", dbg_idx, 2'd0);
        idle(1'b0);
        chk("misalign ser_reset pulse", ser_reset, 1'b0);
        chk("misalign resync_count", resync_count, 16'd1);

        // Timeout: resync pulse lands 21 cycles after the 2nd byte is sampled.
        reset_dut();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        first_k = -1;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            idle(1'b0);
            if (ser_reset) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("timeout first pulse cycle", 64'(first_k - 1), 64'd21);
        chk("timeout pulse count", 64'(pulses), 64'd1);
        chk("timeout resync_count", resync_count, 16'd1);
        chk("timeout state", dbg_state, S_IDLE);
        chk("timeout idx", dbg_idx, 2'd0);

        // A byte in the timeout cycle cancels the resync.
        reset_dut();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) idle(1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            idle(1'b0);
            if (ser_reset) pulses++;
        end
        chk("late byte no pulse", 64'(pulses), 64'd0);
        chk("late byte resync_count", resync_count, 16'd0);
        chk("late byte idx", dbg_idx, 2'd3);
        chk("late byte state", dbg_state, S_PARTIAL);

        // Seven words at frame size 3: done after writes 3 and 6.
        reset_dut();
        mask = 0;
        for (int d = 0; d < 16; d++) begin
            drive(1'b0, (d % 2 == 0) && (d < 14), 32'(d), 1'b0, 1'b0);
            if (frame_done) mask |= (1 << d);
        end
        chk("frame done pattern", 64'(mask), 64'((1 << 6) | (1 << 12)));
        chk("frame words_in_frame", words_in_frame, 16'd1);
        chk("frame drop_count", drop_count, 16'd0);

        // Async reset mid-word with a held word behind a full FIFO.
        reset_dut();
        drive(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0);
        idle(1'b1);
        chk("pre-reset held data", wr_data, 32'hCAFEF00D);
        chk("pre-reset overflow", overflow, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs",
            {wr_en, wr_data, overflow, frame_done, ser_reset, words_in_frame,
             drop_count, resync_count, dbg_state, dbg_idx}, '0);
        @(negedge clk);
        fifo_full = 1'b0;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            if (wr_en) pulses++;
        end
        chk("post-reset no write", 64'(pulses), 64'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, i == 3, 32'h76543210, 1'b0, 1'b0);
        idle(1'b0);
        chk("post-reset word wr_en", wr_en, 1'b1);
        chk("post-reset word data", wr_data, 32'h76543210);
        chk("post-reset resync_count", resync_count, 16'd0);
        chk("post-reset idx", dbg_idx, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
